wb_cpu_master: RTL and testbench



---
 rtl/wb_cpu_master.sv | 160 ++++++++++++++++
 tb/tb_wb_cpu_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_master.sv
// wb_cpu_master: bridges the J1 CPU data-memory port onto a pipelined Wishbone bus.
// One outstanding transfer at a time. Each CPU request becomes one strobe cycle.
// Hung cycles are aborted after TIMEOUT cycles in REQ+WAIT.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   cpu_req/we/adr/dat_w  CPU request, sampled only while cpu_rdy=1
//   cpu_rdy            bridge idle; combinational (state == IDLE)
//   cpu_done/err       one-cycle completion pulse; err marks a timeout abort
//   cpu_dat_r          read data, valid with cpu_done on reads
//   wb_*               Wishbone pipelined master interface
module wb_cpu_master #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_dat_w,
  output logic          cpu_rdy,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic [DW-1:0] cpu_dat_r,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack,
  input  logic          wb_stall
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_o_q, dat_o_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_r_q, dat_r_d;
  logic          term;
  logic [CntW-1:0] cnt_inc;

  assign term    = (cnt_q == TermCnt);
  // Saturate rather than wrap; the FSM leaves REQ/WAIT before this matters.
  assign cnt_inc = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_o_d = dat_o_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dat_r_d = dat_r_q;
    unique case (state_q)
      StIdle: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (cpu_req) begin
          we_d    = cpu_we;
          adr_d   = cpu_adr;
          dat_o_d = cpu_dat_w;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        // Acks are not legal before acceptance, so only stall and timeout matter here.
        if (term) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          dat_r_d = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (!wb_stall) begin
            stb_d   = 1'b0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // An ack on the terminal-count cycle still completes normally.
        if (wb_ack) begin
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) dat_r_d = wb_dat_i;
          state_d = StIdle;
        end else if (term) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          dat_r_d = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_o_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_o_q <= dat_o_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
    end
  end

  assign cpu_rdy   = (state_q == StIdle);
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_dat_r = dat_r_q;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = stb_q;
  assign wb_we     = we_q;
  assign wb_adr    = adr_q;
  assign wb_dat_o  = dat_o_q;

endmodule

// File: tb/tb_wb_cpu_master.sv
// Bench for wb_cpu_master with TIMEOUT=8. Each transfer is described by its stall
// count s and ack delay d (WAIT cycles before ack). The reference model predicts
// the outcome arithmetically from the total busy time t = s + d + 2.
module tb_wb_cpu_master;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic          clk, rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_dat_w;
  logic          cpu_rdy, cpu_done, cpu_err;
  logic [DW-1:0] cpu_dat_r;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_ack, wb_stall;

  wb_cpu_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_dat_w(cpu_dat_w),
    .cpu_rdy(cpu_rdy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_dat_r(cpu_dat_r),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_stall(wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] slv_mem [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] exp_dat_r;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic xfer(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                      input int s, input int d);
    int t, kd, exp_stb;
    logic exp_err;
    int stb_cnt = 0;
    int bad = 0;
    int done_at = 0;
    int done_cnt = 0;
    logic err_seen = 1'b0;
    logic [15:0] r_seen = '0;
    logic cyc_at_done = 1'b1;
    t = s + d + 2;
    if (t <= TO) begin
      kd = t + 1;
      exp_err = 1'b0;
      exp_stb = s + 1;
      if (we) ref_mem[adr] = dat;
      else exp_dat_r = ref_mem[adr];
    end else begin
      kd = TO + 1;
      exp_err = 1'b1;
      exp_stb = (s + 1 < TO) ? s + 1 : TO;
      exp_dat_r = '0;
    end
    check_eq("rdy_before_req", 32'(cpu_rdy), 32'd1);
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_dat_w = dat;
    wb_stall = 1'b0; wb_ack = 1'b0;
    for (int k = 1; k <= kd; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cpu_we = 1'($urandom); cpu_adr = 16'($urandom); cpu_dat_w = 16'($urandom);
      if (wb_stb) begin
        stb_cnt++;
        if (wb_adr !== adr || wb_we !== we || (we && wb_dat_o !== dat)) bad++;
      end
      if (cpu_done) begin
        done_cnt++; done_at = k; err_seen = cpu_err; r_seen = cpu_dat_r; cyc_at_done = wb_cyc;
      end
      if (k < kd) begin
        wb_stall = (k <= s);
        wb_ack   = (k == s + 2 + d);
        wb_dat_i = 16'($urandom);
        if (wb_ack) begin
          if (wb_we) slv_mem[wb_adr] = wb_dat_o;
          else wb_dat_i = slv_mem[wb_adr];
        end
      end else begin
        wb_stall = 1'b0;
        wb_ack   = 1'b0;
      end
    end
    check_eq("done_cycle", 32'(done_at), 32'(kd));
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("err", 32'(err_seen), 32'(exp_err));
    check_eq("dat_r", 32'(r_seen), 32'(exp_dat_r));
    check_eq("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
    check_eq("bus_fields", 32'(bad), 32'd0);
    check_eq("cyc_at_done", 32'(cyc_at_done), 32'd0);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_dat_w = '0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_stall = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end
    exp_dat_r = '0;
    @(negedge clk);
    check_eq("rst_cyc_stb", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
    check_eq("rst_adr_dat", 32'({wb_adr, wb_dat_o}), 32'd0);
    check_eq("rst_cpu_out", 32'({cpu_done, cpu_err, cpu_dat_r}), 32'd0);
    check_eq("rst_rdy", 32'(cpu_rdy), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    slv_mem[16'h0012] = 16'hBEEF;
    ref_mem[16'h0012] = 16'hBEEF;
    xfer(1'b0, 16'h0012, 16'h0000, 0, 0);      // basic read
    xfer(1'b1, 16'h07FF, 16'hA5A5, 0, 0);      // write, back-to-back
    xfer(1'b0, 16'h07FF, 16'h0000, 0, 0);      // read back
    xfer(1'b0, 16'h0012, 16'h0000, 4, 0);      // 4-cycle stall
    xfer(1'b0, 16'h07FF, 16'h0000, 0, NEVER);  // timeout in WAIT
    xfer(1'b0, 16'h0012, 16'h0000, 0, 0);      // recovery
    xfer(1'b0, 16'h07FF, 16'h0000, 0, 6);      // ack on terminal count in WAIT
    xfer(1'b1, 16'h0040, 16'h1234, 6, 0);      // ack on terminal count after long stall
    xfer(1'b0, 16'h0012, 16'h0000, 8, 0);      // timeout while still stalled

    // Stray ack while idle must not produce a completion.
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check_eq("stray_ack_done", 32'(cpu_done), 32'd0);
    @(negedge clk);
    check_eq("stray_ack_done2", 32'(cpu_done), 32'd0);
    check_eq("stray_ack_cyc", 32'(wb_cyc), 32'd0);

    for (int i = 0; i < 40; i++) begin
      int s, d;
      s = $urandom_range(0, 4);
      d = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 4);
      xfer(1'($urandom), 16'($urandom_range(0, 15)), 16'($urandom), s, d);
    end

    // Asynchronous reset while the bridge waits for an ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0012;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_cyc", 32'({wb_cyc, wb_stb}), 32'd0);
    check_eq("arst_rdy", 32'(cpu_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_dat_r = '0;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_done) done_cnt++;
    end
    check_eq("arst_no_done", 32'(done_cnt), 32'd0);
    xfer(1'b0, 16'h0012, 16'h0000, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
